// File: rtl/mod_seq_counter.sv
// Loadable multi-mode sequence counter: binary up/down, Gray up and ping-pong over 0..MODULUS-1.
// Optional build macro MOD_SEQ_COUNTER_PRESCALE_EN adds an 8-bit step prescaler (presc input).
module mod_seq_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
  input  logic [7:0]       presc,
`endif
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ModeUp   = 2'b00,
    ModeDown = 2'b01,
    ModeGray = 2'b10,
    ModePing = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MaxIdx = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam bit               Single = (MODULUS == 1);
  localparam bit               Full   = (MODULUS == (32'd1 << WIDTH));

  mode_e            mode_sel;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_val;
  logic             at_max, at_zero, at_terminal;
  logic             pc_hit, step_hit;

  assign mode_sel = mode_e'(mode);
  assign at_max   = (cnt_q == MaxIdx);
  assign at_zero  = (cnt_q == '0);

  // Out-of-range load values clamp to the last index; a full-range modulus needs no clamp.
  if (Full) begin : g_no_clamp
    assign load_val = d;
  end else begin : g_clamp
    assign load_val = (d > MaxIdx) ? MaxIdx : d;
  end

`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
  logic [7:0] pc_q, pc_d;

  assign pc_hit = (pc_q == presc);

  always_comb begin
    pc_d = pc_q;
    if (!load_n) begin
      pc_d = '0;
    end else if (en) begin
      pc_d = pc_hit ? 8'd0 : pc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`else
  assign pc_hit = 1'b1;
`endif

  assign step_hit = en & load_n & pc_hit;

  always_comb begin
    at_terminal = 1'b0;
    unique case (mode_sel)
      ModeUp, ModeGray: at_terminal = at_max;
      ModeDown:         at_terminal = at_zero;
      ModePing:         at_terminal = (dir_q & at_max) | (~dir_q & at_zero);
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (!load_n) begin
      cnt_d = load_val;
    end else if (step_hit) begin
      wrap_d = at_terminal;
      unique case (mode_sel)
        ModeUp, ModeGray: begin
          dir_d = 1'b1;
          cnt_d = at_max ? '0 : cnt_q + One;
        end
        ModeDown: begin
          dir_d = 1'b0;
          cnt_d = at_zero ? MaxIdx : cnt_q - One;
        end
        ModePing: begin
          // Reverse at an endpoint and take the first step of the new direction in the same cycle,
          // so each endpoint is seen once per bounce. A single-state counter only flips dir.
          if (dir_q && at_max) begin
            dir_d = 1'b0;
            cnt_d = Single ? '0 : cnt_q - One;
          end else if (!dir_q && at_zero) begin
            dir_d = 1'b1;
            cnt_d = Single ? '0 : One;
          end else if (dir_q) begin
            cnt_d = cnt_q + One;
          end else begin
            cnt_d = cnt_q - One;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = (mode_sel == ModeGray) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;
  // Gated by rst_n so tc stays low while the counter is held in reset.
  assign tc   = rst_n & step_hit & at_terminal;

endmodule

// File: tb/tb_mod_seq_counter.sv
// Self-checking bench for mod_seq_counter: four instances (MODULUS 10/16/4/1) on shared stimulus,
// compared each cycle with an arithmetic reference model, plus directed vector tables.
module tb_mod_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, load_n;
  logic [7:0] d;
  logic [1:0] mode;
  logic [7:0] presc;

  logic [7:0] q10;
  logic [3:0] q16;
  logic [2:0] q4;
  logic [1:0] q1;
  logic [3:0] dir_v, tc_v, wrap_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_seq_counter #(.WIDTH(8), .MODULUS(10)) u10 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .d(d[7:0]),
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .mode(mode), .q(q10), .dir(dir_v[0]), .tc(tc_v[0]), .wrap(wrap_v[0]));

  mod_seq_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .d(d[3:0]),
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .mode(mode), .q(q16), .dir(dir_v[1]), .tc(tc_v[1]), .wrap(wrap_v[1]));

  mod_seq_counter #(.WIDTH(3), .MODULUS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .d(d[2:0]),
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .mode(mode), .q(q4), .dir(dir_v[2]), .tc(tc_v[2]), .wrap(wrap_v[2]));

  mod_seq_counter #(.WIDTH(2), .MODULUS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .d(d[1:0]),
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .mode(mode), .q(q1), .dir(dir_v[3]), .tc(tc_v[3]), .wrap(wrap_v[3]));

  logic [31:0] aq [4];
  assign aq[0] = 32'(q10);
  assign aq[1] = 32'(q16);
  assign aq[2] = 32'(q4);
  assign aq[3] = 32'(q1);

  // Reference model: plain index arithmetic per instance.
  int mod_c [4] = '{10, 16, 4, 1};
  int wid_c [4] = '{8, 4, 3, 2};
  int idx   [4];
  bit mdir  [4];
  bit mwrap [4];
  int mpc;

  function automatic bit at_term(int i);
    case (mode)
      2'b00, 2'b10: return idx[i] == mod_c[i] - 1;
      2'b01:        return idx[i] == 0;
      default:      return mdir[i] ? (idx[i] == mod_c[i] - 1) : (idx[i] == 0);
    endcase
  endfunction

  function automatic int exp_q(int i);
    return (mode == 2'b10) ? (idx[i] ^ (idx[i] >> 1)) : idx[i];
  endfunction

  function automatic int exp_tc(int i);
    return int'(rst_n && en && load_n && (mpc == int'(presc)) && at_term(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      idx[i] = 0; mdir[i] = 1'b1; mwrap[i] = 1'b0;
    end
    mpc = 0;
  endtask

  task automatic advance(int i);
    case (mode)
      2'b00, 2'b10: begin idx[i] = (idx[i] + 1) % mod_c[i]; mdir[i] = 1'b1; end
      2'b01:        begin idx[i] = (idx[i] + mod_c[i] - 1) % mod_c[i]; mdir[i] = 1'b0; end
      default: begin
        if (mdir[i] && idx[i] == mod_c[i] - 1) mdir[i] = 1'b0;
        else if (!mdir[i] && idx[i] == 0)      mdir[i] = 1'b1;
        if (mod_c[i] > 1) idx[i] = mdir[i] ? idx[i] + 1 : idx[i] - 1;
      end
    endcase
  endtask

  task automatic model_step();
    if (!load_n) begin
      for (int i = 0; i < 4; i++) begin
        int dv;
        dv = int'(d) & ((1 << wid_c[i]) - 1);
        idx[i] = (dv > mod_c[i] - 1) ? mod_c[i] - 1 : dv;
        mwrap[i] = 1'b0;
      end
      mpc = 0;
    end else if (en && mpc == int'(presc)) begin
      for (int i = 0; i < 4; i++) begin
        mwrap[i] = at_term(i);
        advance(i);
      end
      mpc = 0;
    end else begin
      if (en) mpc = (mpc + 1) % 256;
      for (int i = 0; i < 4; i++) mwrap[i] = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m%0d.q", mod_c[i]), aq[i], 32'(exp_q(i)));
      chk($sformatf("m%0d.dir", mod_c[i]), 32'(dir_v[i]), 32'(mdir[i]));
      chk($sformatf("m%0d.wrap", mod_c[i]), 32'(wrap_v[i]), 32'(mwrap[i]));
      chk($sformatf("m%0d.tc", mod_c[i]), 32'(tc_v[i]), 32'(exp_tc(i)));
    end
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    @(negedge clk);
    check_model();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_model();
    chk("rst.q10", 32'(q10), 32'd0);
    chk("rst.dir10", 32'(dir_v[0]), 32'd1);
    chk("rst.wrap10", 32'(wrap_v[0]), 32'd0);
    chk("rst.tc", 32'(tc_v), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic       load_n;
    logic [7:0] d;
    logic [1:0] mode;
    int         q;
    int         dir;
    int         tc;
    int         wrap;
  } vec_t;

  function automatic vec_t mkv(logic e, logic l, logic [7:0] dv, logic [1:0] m,
                               int eq, int ed, int et, int ew);
    vec_t v;
    v.en = e; v.load_n = l; v.d = dv; v.mode = m;
    v.q = eq; v.dir = ed; v.tc = et; v.wrap = ew;
    return v;
  endfunction

  vec_t vt[$];
  int   gray_exp [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  int   pp_q     [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
  int   pp_dir   [8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
  int   pp_wrap  [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    rst_n = 1'b0; en = 1'b1; load_n = 1'b1; d = '0; mode = 2'b00; presc = '0;
    model_reset();
    @(negedge clk);
    check_model();
    chk("reset.tc", 32'(tc_v), 32'd0);
    rst_n = 1'b1;

    // Binary up through the wrap, then load 7 and count down past zero, clamp and hold.
    for (int k = 0; k < 12; k++) begin
      int qv;
      qv = (k + 1) % 10;
      vt.push_back(mkv(1'b1, 1'b1, 8'd0, 2'b00, qv, 1, int'(qv == 9), int'(k == 9)));
    end
    vt.push_back(mkv(1'b1, 1'b0, 8'd7, 2'b01, 7, 1, 0, 0));
    for (int k = 0; k < 9; k++) begin
      int qv;
      qv = (16 - k) % 10;
      vt.push_back(mkv(1'b1, 1'b1, 8'd0, 2'b01, qv, 0, int'(qv == 0), int'(k == 7)));
    end
    vt.push_back(mkv(1'b0, 1'b0, 8'd200, 2'b01, 9, 0, 0, 0));
    vt.push_back(mkv(1'b0, 1'b1, 8'd0, 2'b01, 9, 0, 0, 0));
    vt.push_back(mkv(1'b0, 1'b1, 8'd0, 2'b01, 9, 0, 0, 0));
    vt.push_back(mkv(1'b1, 1'b1, 8'd0, 2'b01, 8, 0, 0, 0));

    foreach (vt[k]) begin
      en = vt[k].en; load_n = vt[k].load_n; d = vt[k].d; mode = vt[k].mode;
      tick();
      chk($sformatf("vec%0d.q", k), 32'(q10), 32'(vt[k].q));
      chk($sformatf("vec%0d.dir", k), 32'(dir_v[0]), 32'(vt[k].dir));
      chk($sformatf("vec%0d.tc", k), 32'(tc_v[0]), 32'(vt[k].tc));
      chk($sformatf("vec%0d.wrap", k), 32'(wrap_v[0]), 32'(vt[k].wrap));
    end

    // Gray up on MODULUS=16: exact codes and single-bit steps.
    en = 1'b1; load_n = 1'b0; d = '0; mode = 2'b10;
    tick();
    load_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] prev;
      prev = q16;
      tick();
      chk($sformatf("gray%0d.q", k), 32'(q16), 32'(gray_exp[k]));
      chk($sformatf("gray%0d.bits", k), 32'($countones(q16 ^ prev)), 32'd1);
    end

    // Ping-pong on MODULUS=4.
    load_n = 1'b0; d = '0; mode = 2'b11;
    tick();
    load_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("pp%0d.q", k), 32'(q4), 32'(pp_q[k]));
      chk($sformatf("pp%0d.dir", k), 32'(dir_v[2]), 32'(pp_dir[k]));
      chk($sformatf("pp%0d.wrap", k), 32'(wrap_v[2]), 32'(pp_wrap[k]));
    end

    // Mode 01 into mode 11 keeps the downward direction.
    mode = 2'b01;
    tick();
    mode = 2'b11;
    tick();
    chk("pp.keepdir", 32'(dir_v[0]), 32'd0);

`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
    load_n = 1'b0; d = '0; mode = 2'b00; presc = 8'd2;
    tick();
    load_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("presc%0d.q", k), 32'(q10), 32'((k / 3) % 10));
    end
    presc = '0;
`endif

    // Asynchronous reset mid-count with tc otherwise asserting conditions present.
    mode = 2'b01; en = 1'b1; load_n = 1'b1;
    tick();
    async_reset();
    tick();

    for (int k = 0; k < 600; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      load_n = ($urandom_range(0, 9) != 0);
      d      = 8'($urandom);
      if (k % 7 == 0) mode = 2'($urandom);
`ifdef MOD_SEQ_COUNTER_PRESCALE_EN
      if (k % 50 == 0) presc = 8'($urandom_range(0, 3));
`endif
      tick();
      if (k % 97 == 50) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
